// File: rtl/victim_cache_lru.sv
// victim_cache_lru: fully associative victim cache with FIFO or true-LRU replacement
module victim_cache_lru #(
  parameter int CAPACITY = 8,
  parameter int TAG_W = 26,
  parameter int LINE_W = 512,
  parameter int REPL_MODE = 0,
  localparam int AW = $clog2(CAPACITY),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              r_req,
  input  logic [TAG_W-1:0]  r_tag,
  input  logic              r_take,
  output logic              r_valid,
  output logic              r_hit,
  output logic [LINE_W-1:0] r_data,
  input  logic              w_en,
  input  logic [TAG_W-1:0]  w_tag,
  input  logic [LINE_W-1:0] w_data,
  input  logic              inv_all,
  output logic [CW-1:0]     count,
  output logic              full
);
  typedef logic [CAPACITY-1:0][AW-1:0] age_t;
  logic [CAPACITY-1:0] valid, valid_n;
  logic [TAG_W-1:0] tags [CAPACITY];
  logic [LINE_W-1:0] lines [CAPACITY];
  logic [AW-1:0] ptr, r_idx, w_idx, free_idx, lru_idx, alloc_idx;
  age_t age, age_n;
  logic r_any, w_any, free_any, evict, r_touch, hit_n;
  logic [CW-1:0] cnt_n;
  function automatic age_t age_init();
    for (int i = 0; i < CAPACITY; i++) age_init[i] = AW'(i);
  endfunction
  // move entry k to most-recent; everything younger than it ages by one
  function automatic age_t touch(input age_t a, input logic [AW-1:0] k);
    touch = a;
    for (int j = 0; j < CAPACITY; j++)
      if (j == int'(k)) touch[j] = '0;
      else if (a[j] < a[k]) touch[j] = a[j] + 1'b1;
  endfunction
  always_comb begin
    r_any = 1'b0;
    w_any = 1'b0;
    free_any = 1'b0;
    r_idx = '0;
    w_idx = '0;
    free_idx = '0;
    lru_idx = '0;
    for (int i = CAPACITY - 1; i >= 0; i--) begin
      if (valid[i] && tags[i] == r_tag) begin r_any = 1'b1; r_idx = AW'(i); end
      if (valid[i] && tags[i] == w_tag) begin w_any = 1'b1; w_idx = AW'(i); end
      if (!valid[i]) begin free_any = 1'b1; free_idx = AW'(i); end
      if (age[i] == AW'(CAPACITY - 1)) lru_idx = AW'(i);
    end
    evict = w_en && !w_any && !free_any;
    alloc_idx = w_any ? w_idx : free_any ? free_idx : (REPL_MODE != 0) ? lru_idx : ptr;
    r_touch = r_req && !r_take && r_any;
    hit_n = r_req && r_any && !inv_all;
    valid_n = valid;
    if (r_req && r_take && r_any) valid_n[r_idx] = 1'b0;
    if (w_en) valid_n[alloc_idx] = 1'b1;
    age_n = r_touch ? touch(age, r_idx) : age;
    if (w_en) age_n = touch(age_n, alloc_idx);
    if (inv_all) begin
      valid_n = '0;
      age_n = age_init();
    end
    cnt_n = '0;
    for (int i = 0; i < CAPACITY; i++) cnt_n = cnt_n + CW'(valid_n[i]);
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid <= '0;
      ptr <= '0;
      age <= age_init();
      count <= '0;
      full <= 1'b0;
      r_valid <= 1'b0;
      r_hit <= 1'b0;
      r_data <= '0;
    end else begin
      valid <= valid_n;
      age <= (REPL_MODE != 0) ? age_n : age;
      ptr <= inv_all ? '0 : (evict && REPL_MODE == 0) ? ptr + 1'b1 : ptr;
      count <= cnt_n;
      full <= cnt_n == CW'(CAPACITY);
      r_valid <= r_req;
      r_hit <= hit_n;
      r_data <= hit_n ? lines[r_idx] : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rstn && w_en && !inv_all) begin
      tags[alloc_idx] <= w_tag;
      lines[alloc_idx] <= w_data;
    end
  end
endmodule

// File: tb/tb_victim_cache_lru.sv
// tb_victim_cache_lru: FIFO and LRU instances against a recency-list reference model
module tb_victim_cache_lru;
  localparam int CAP = 8;
  logic clk = 1'b0, rstn, r_req, r_take, w_en, inv_all;
  logic [25:0] r_tag, w_tag;
  logic [511:0] w_data;
  logic rv_f, rh_f, full_f, rv_l, rh_l, full_l;
  logic [511:0] rd_f, rd_l;
  logic [3:0] cnt_f, cnt_l;
  int n_chk = 0, n_pass = 0;
  bit started = 0;
  always #5 clk = ~clk;
  victim_cache_lru #(.CAPACITY(CAP), .TAG_W(26), .LINE_W(512), .REPL_MODE(0)) dut_f (
    .clk(clk), .rstn(rstn), .r_req(r_req), .r_tag(r_tag), .r_take(r_take),
    .r_valid(rv_f), .r_hit(rh_f), .r_data(rd_f), .w_en(w_en), .w_tag(w_tag),
    .w_data(w_data), .inv_all(inv_all), .count(cnt_f), .full(full_f));
  victim_cache_lru #(.CAPACITY(CAP), .TAG_W(26), .LINE_W(512), .REPL_MODE(1)) dut_l (
    .clk(clk), .rstn(rstn), .r_req(r_req), .r_tag(r_tag), .r_take(r_take),
    .r_valid(rv_l), .r_hit(rh_l), .r_data(rd_l), .w_en(w_en), .w_tag(w_tag),
    .w_data(w_data), .inv_all(inv_all), .count(cnt_l), .full(full_l));
  // model state per mode (0 = FIFO, 1 = LRU); ord is a recency list, most recent first
  bit mv[2][CAP];
  logic [25:0] mt[2][CAP];
  logic [511:0] md[2][CAP];
  int mptr[2];
  int ord[2][CAP];
  bit e_rv[2], e_rh[2];
  logic [511:0] e_rd[2];
  int e_cnt[2];
  function automatic logic [511:0] pat(input logic [25:0] t);
    return {16{{6'b0, t}}};
  endfunction
  task automatic check_s(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t got %0h expected %0h", nm, $time, act, exp);
  endtask
  task automatic check_d(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t got %h expected %h", nm, $time, act, exp);
  endtask
  function automatic void clear_model(input int m);
    for (int i = 0; i < CAP; i++) begin mv[m][i] = 0; ord[m][i] = i; end
    mptr[m] = 0;
  endfunction
  function automatic void to_front(input int m, input int k);
    int p = 0;
    for (int i = 0; i < CAP; i++) if (ord[m][i] == k) p = i;
    for (int q = p; q > 0; q--) ord[m][q] = ord[m][q-1];
    ord[m][0] = k;
  endfunction
  function automatic void model_step(input int m);
    int hr = -1, hw = -1, fr = -1, wi;
    bit ev;
    if (!rstn) begin
      clear_model(m);
      e_rv[m] = 0; e_rh[m] = 0; e_rd[m] = '0; e_cnt[m] = 0;
      return;
    end
    for (int i = 0; i < CAP; i++) begin
      if (mv[m][i] && mt[m][i] == r_tag) hr = i;
      if (mv[m][i] && mt[m][i] == w_tag) hw = i;
      if (!mv[m][i] && fr < 0) fr = i;
    end
    e_rv[m] = r_req;
    e_rh[m] = r_req && hr >= 0 && !inv_all;
    e_rd[m] = e_rh[m] ? md[m][hr] : '0;
    if (inv_all) clear_model(m);
    else begin
      ev = hw < 0 && fr < 0;
      wi = hw >= 0 ? hw : fr >= 0 ? fr : (m == 1 ? ord[m][CAP-1] : mptr[m]);
      if (r_req && r_take && hr >= 0) mv[m][hr] = 0;
      else if (r_req && hr >= 0) to_front(m, hr);
      if (w_en) begin
        mv[m][wi] = 1; mt[m][wi] = w_tag; md[m][wi] = w_data;
        to_front(m, wi);
        if (ev) mptr[m] = (mptr[m] + 1) % CAP;
      end
    end
    e_cnt[m] = 0;
    for (int i = 0; i < CAP; i++) e_cnt[m] += int'(mv[m][i]);
  endfunction
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) model_step(m);
    started = 1;
  end
  always @(negedge clk) if (started) begin
    check_s("f_r_valid", 32'(rv_f), 32'(e_rv[0]));
    check_s("f_r_hit", 32'(rh_f), 32'(e_rh[0]));
    check_d("f_r_data", rd_f, e_rd[0]);
    check_s("f_count", 32'(cnt_f), e_cnt[0]);
    check_s("f_full", 32'(full_f), 32'(e_cnt[0] == CAP));
    check_s("l_r_valid", 32'(rv_l), 32'(e_rv[1]));
    check_s("l_r_hit", 32'(rh_l), 32'(e_rh[1]));
    check_d("l_r_data", rd_l, e_rd[1]);
    check_s("l_count", 32'(cnt_l), e_cnt[1]);
    check_s("l_full", 32'(full_l), 32'(e_cnt[1] == CAP));
  end
  task automatic op(input bit rq, input bit tk, input logic [25:0] rt, input bit we,
                    input logic [25:0] wt, input logic [511:0] wd, input bit inv);
    r_req = rq; r_take = tk; r_tag = rt; w_en = we; w_tag = wt; w_data = wd; inv_all = inv;
    @(negedge clk);
    r_req = 0; r_take = 0; w_en = 0; inv_all = 0;
  endtask
  task automatic rd(input logic [25:0] t, input bit tk);
    op(1, tk, t, 0, '0, '0, 0);
  endtask
  task automatic wr(input logic [25:0] t, input logic [511:0] d);
    op(0, 0, '0, 1, t, d, 0);
  endtask
  initial begin
    rstn = 0; r_req = 0; r_take = 0; w_en = 0; inv_all = 0;
    r_tag = '0; w_tag = '0; w_data = '0;
    repeat (2) @(negedge clk);
    check_s("rst_count", 32'(cnt_f), 0);
    check_s("rst_full", 32'(full_l), 0);
    check_s("rst_r_valid", 32'(rv_l), 0);
    rstn = 1;
    for (int t = 16; t < 24; t++) wr(26'(t), pat(26'(t)));
    check_s("fill_count_f", 32'(cnt_f), 8);
    check_s("fill_count_l", 32'(cnt_l), 8);
    check_s("fill_full_f", 32'(full_f), 1);
    rd(26'h13, 0);
    check_s("rd13_hit", 32'(rh_f), 1);
    check_d("rd13_data", rd_l, pat(26'h13));
    rd(26'h10, 0);
    wr(26'h20, pat(26'h20));
    rd(26'h10, 0);
    check_s("fifo_evict10_hit", 32'(rh_f), 0);
    check_d("fifo_evict10_data", rd_f, '0);
    check_s("lru_keep10_hit", 32'(rh_l), 1);
    rd(26'h11, 0);
    check_s("fifo_keep11_hit", 32'(rh_f), 1);
    check_s("lru_evict11_hit", 32'(rh_l), 0);
    check_s("evict_count", 32'(cnt_f), 8);
    wr(26'h12, pat(26'hABC));
    check_s("whit_count_l", 32'(cnt_l), 8);
    rd(26'h12, 0);
    check_d("whit_data_l", rd_l, pat(26'hABC));
    wr(26'h21, pat(26'h21));
    rd(26'h11, 0);
    check_s("fifo_evict11_hit", 32'(rh_f), 0);
    rd(26'h15, 1);
    check_s("take_hit", 32'(rh_l), 1);
    check_s("take_count_f", 32'(cnt_f), 7);
    check_s("take_count_l", 32'(cnt_l), 7);
    rd(26'h15, 0);
    check_s("taken_miss", 32'(rh_f), 0);
    wr(26'h30, pat(26'h30));
    check_s("refill_count", 32'(cnt_l), 8);
    rd(26'h16, 0);
    check_s("no_evict_hit", 32'(rh_f), 1);
    op(1, 1, 26'h16, 1, 26'h16, pat(26'h99), 0);
    check_s("same_cyc_hit", 32'(rh_f), 1);
    check_d("same_cyc_old", rd_l, pat(26'h16));
    check_s("same_cyc_count", 32'(cnt_f), 8);
    rd(26'h16, 0);
    check_d("same_cyc_new", rd_f, pat(26'h99));
    op(1, 0, 26'h16, 1, 26'h40, pat(26'h40), 1);
    check_s("inv_r_valid", 32'(rv_f), 1);
    check_s("inv_r_hit", 32'(rh_l), 0);
    check_s("inv_count", 32'(cnt_l), 0);
    rd(26'h40, 0);
    check_s("inv_write_dropped", 32'(rh_f), 0);
    wr(26'h50, pat(26'h50));
    rd(26'h50, 0);
    rstn = 0;
    op(1, 0, 26'h50, 0, '0, '0, 0);
    check_s("rst_mid_r_valid", 32'(rv_f), 0);
    check_s("rst_mid_count", 32'(cnt_l), 0);
    check_d("rst_mid_r_data", rd_l, '0);
    rstn = 1;
    for (int c = 0; c < 3000; c++) begin
      rstn = $urandom_range(0, 99) != 0;
      r_req = $urandom_range(0, 9) < 6;
      r_take = $urandom_range(0, 9) < 3;
      r_tag = 26'(16 + $urandom_range(0, 11));
      w_en = $urandom_range(0, 1) == 1;
      w_tag = 26'(16 + $urandom_range(0, 11));
      for (int k = 0; k < 16; k++) w_data[32*k +: 32] = $urandom();
      inv_all = $urandom_range(0, 99) < 3;
      @(negedge clk);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
